control_loop_sequencer: RTL and testbench
=========================================

Name: control_loop_sequencer

Overview:
- Schedules one closed-loop wall-follower iteration per 32 Hz control tick: ADC sample request, distance LUT settle, PID step, duty-cycle register load, telemetry FIFO push.
- Sits between clk_enable/i2c_adc_fsm/adc_lut and pid_controller/duty flops/telemetry FIFO.
- Replaces the free-running tick fan-out so that every PID update uses a fresh, settled sample.
- Detects ADC timeouts and tick overruns, and forces a safe duty state on repeated faults.

Parameters:
ADC_TIMEOUT_CYCLES, 200000, max clk cycles from adc_start to adc_done (2 ms at 100 MHz)
LUT_LATENCY, 2, clk cycles from adc_done until LUT outputs are valid
PID_LATENCY, 3, clk cycles from pid_step until control_out is valid
MAX_FAULTS, 3, consecutive ADC timeouts before fault latches
CNT_WIDTH, 8, width of the saturating overrun/timeout counters

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
tick_in  in  1  one-cycle 32 Hz control tick
run_en  in  1  motor enable (bumper toggle)
adc_start  out  1  one-cycle conversion request to ADC FSM
adc_done  in  1  one-cycle sample-complete pulse
pid_step  out  1  one-cycle clk_en to pid_controller
duty_load  out  1  one-cycle clk_en to duty flops
duty_safe  out  1  high forces duty flops clear (drives clr_n low externally)
fifo_full  in  1  telemetry FIFO full
fifo_wr_en  out  1  telemetry push strobe
busy  out  1  high whenever state != IDLE
fault  out  1  sticky fault flag
overrun_cnt  out  CNT_WIDTH  ticks dropped while busy (saturating)
timeout_cnt  out  CNT_WIDTH  total ADC timeouts (saturating)
state_dbg  out  3  current state encoding, for ILA

Behaviour:
- Reset: state IDLE. All strobes 0, busy 0, fault 0, counters 0, duty_safe 1.
- duty_safe = fault | ~run_en (registered).
- States: IDLE, ADC_REQ, ADC_WAIT, LUT_WAIT, PID_STEP, PID_WAIT, DUTY_LOAD, LOG.
- IDLE -> ADC_REQ on tick_in & run_en & ~fault. ticks are ignored while run_en is low or fault is set.
- ADC_REQ: adc_start = 1 for exactly 1 cycle; timeout counter loads 0; -> ADC_WAIT.
- ADC_WAIT:
  - On adc_done -> LUT_WAIT; consecutive-fault count clears.
  - If timer reaches ADC_TIMEOUT_CYCLES-1 without adc_done: timeout_cnt++, consecutive-fault count++, -> IDLE.
  - If the consecutive count reaches MAX_FAULTS, fault sets in the same cycle.
  - adc_done arriving in the same cycle as the timeout counts as success.
- LUT_WAIT: wait LUT_LATENCY cycles -> PID_STEP.
- PID_STEP: pid_step = 1 for 1 cycle -> PID_WAIT.
- PID_WAIT: wait PID_LATENCY cycles -> DUTY_LOAD.
- DUTY_LOAD: duty_load = 1 for 1 cycle -> LOG.
- LOG:
  - fifo_wr_en = 1 for 1 cycle if ~fifo_full; the sample is dropped silently if full.
  - -> IDLE.
- Nominal latency from tick to duty_load: 1 + adc + LUT_LATENCY + 1 + PID_LATENCY cycles.
- Overrun: tick_in while busy is dropped and overrun_cnt increments.
- Counters saturate at all-ones and never wrap.
- run_en falling mid-iteration:
  - In ADC_WAIT: keep waiting for adc_done or timeout (the I2C transaction is not aborted), then return to IDLE with no pid_step or duty_load.
  - In any other state: -> IDLE on the next cycle with no further strobes.
- fault clears only on a run_en rising edge (the consecutive-fault count clears too). Counters clear only on reset.
- At most one strobe output is high in any cycle.

Optional Feature:
- Macro SEQ_TELEMETRY_EN.
- Defined: LOG state is present, and fifo_wr_en behaves as specified above.
- Undefined: LOG state is removed, DUTY_LOAD -> IDLE, fifo_wr_en is tied 0, and fifo_full is unused.
- Nominal iteration length shortens by one cycle.

Decomposition:
- Package ctrl_seq_pkg holds:
  - typedef enum logic [2:0] seq_state_t, with IDLE=0 … LOG=7 (used by state_dbg and the ILA);
  - localparam defaults for the timeouts/latencies.
- One sub-module, sat_counter (width-parameterised saturating increment with sync clear), instantiated for overrun_cnt, timeout_cnt and the consecutive-fault count.
- The FSM and wait timers stay in the top module.

Test Plan:
- Nominal: run_en=1, tick, adc_done 50 cycles after adc_start -> pid_step 3 cycles after adc_done; duty_load 4 cycles after pid_step; fifo_wr_en 1 cycle later; busy falls.
- Overrun: second tick 20 cycles into ADC_WAIT -> overrun_cnt=1, single adc_start, iteration completes normally.
- Timeout/fault: ADC_TIMEOUT_CYCLES=100, never send adc_done for 3 ticks:
  - timeout_cnt=3, fault=1, duty_safe=1;
  - fourth tick produces no adc_start;
  - run_en 1->0->1 clears fault.
- Abort: run_en drops during ADC_WAIT, adc_done 10 cycles later -> no pid_step/duty_load, state IDLE.
- FIFO full: fifo_full=1 in LOG -> fifo_wr_en stays 0, duty_load still pulses once.
- Reset mid-PID_WAIT: reset_n low -> all strobes 0 immediately, counters 0, duty_safe 1, state_dbg=0.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared types and default timing for the control-loop sequencer.
// State encodings are exposed on state_dbg for the ILA, so keep them stable.
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADC_REQ   = 3'd1,
    ADC_WAIT  = 3'd2,
    LUT_WAIT  = 3'd3,
    PID_STEP  = 3'd4,
    PID_WAIT  = 3'd5,
    DUTY_LOAD = 3'd6,
    LOG       = 3'd7
  } seq_state_t;

  localparam int unsigned ADC_TIMEOUT_CYCLES_DEF = 200000;
  localparam int unsigned LUT_LATENCY_DEF        = 2;
  localparam int unsigned PID_LATENCY_DEF        = 3;
  localparam int unsigned MAX_FAULTS_DEF         = 3;
  localparam int unsigned CNT_WIDTH_DEF          = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/control_loop_sequencer_if.sv
// Strobe/handshake bundle between the sequencer and the ADC, PID, duty and telemetry blocks.
interface control_loop_sequencer_if;

  logic adc_start;
  logic adc_done;
  logic pid_step;
  logic duty_load;
  logic duty_safe;
  logic fifo_full;
  logic fifo_wr_en;

  modport master (
    output adc_start, pid_step, duty_load, duty_safe, fifo_wr_en,
    input  adc_done, fifo_full
  );

  modport slave (
    input  adc_start, pid_step, duty_load, duty_safe, fifo_wr_en,
    output adc_done, fifo_full
  );

endinterface

// File: rtl/control_loop_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/control_loop_sequencer.sv
// One wall-follower iteration per control tick: ADC request, LUT settle, PID step, duty load, log.
// Build option: define SEQ_TELEMETRY_EN to include the LOG state and telemetry FIFO push.
module control_loop_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned ADC_TIMEOUT_CYCLES = ADC_TIMEOUT_CYCLES_DEF,
  parameter int unsigned LUT_LATENCY        = LUT_LATENCY_DEF,
  parameter int unsigned PID_LATENCY        = PID_LATENCY_DEF,
  parameter int unsigned MAX_FAULTS         = MAX_FAULTS_DEF,
  parameter int unsigned CNT_WIDTH          = CNT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tick_in,
  input  logic                     run_en,
  control_loop_sequencer_if.master bus,
  output logic                     busy,
  output logic                     fault,
  output logic [CNT_WIDTH-1:0]     overrun_cnt,
  output logic [CNT_WIDTH-1:0]     timeout_cnt,
  output logic [2:0]               state_dbg
);

  localparam int unsigned TMR_MAX = max3(ADC_TIMEOUT_CYCLES, LUT_LATENCY, PID_LATENCY);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  seq_state_t           state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 adc_start_q, adc_start_d;
  logic                 pid_step_q, pid_step_d;
  logic                 duty_load_q, duty_load_d;
  logic                 fifo_wr_en_q, fifo_wr_en_d;
  logic                 busy_q, busy_d;
  logic                 fault_q, fault_d;
  logic                 duty_safe_q, duty_safe_d;
  logic                 run_en_q;
  logic                 run_rise;
  logic                 adc_ok;
  logic                 adc_timeout;
  logic                 consec_clr;
  logic [CNT_WIDTH-1:0] consec_cnt;

  assign run_rise    = run_en & ~run_en_q;
  assign adc_ok      = (state_q == ADC_WAIT) && bus.adc_done;
  // adc_done coincident with the last timer cycle wins over the timeout
  assign adc_timeout = (state_q == ADC_WAIT) && !bus.adc_done &&
                       (timer_q == TMR_W'(ADC_TIMEOUT_CYCLES - 1));
  assign consec_clr  = run_rise | adc_ok;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; run_en low aborts everywhere except the in-flight ADC read
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (tick_in && run_en && !fault_q) state_d = ADC_REQ;
      ADC_REQ:   state_d = run_en ? ADC_WAIT : IDLE;
      ADC_WAIT: begin
        if (bus.adc_done)     state_d = run_en ? LUT_WAIT : IDLE;
        else if (adc_timeout) state_d = IDLE;
      end
      LUT_WAIT: begin
        if (!run_en)                                   state_d = IDLE;
        else if (timer_q == TMR_W'(LUT_LATENCY - 1))   state_d = PID_STEP;
      end
      PID_STEP:  state_d = run_en ? PID_WAIT : IDLE;
      PID_WAIT: begin
        if (!run_en)                                   state_d = IDLE;
        else if (timer_q == TMR_W'(PID_LATENCY - 1))   state_d = DUTY_LOAD;
      end
`ifdef SEQ_TELEMETRY_EN
      DUTY_LOAD: state_d = run_en ? LOG : IDLE;
      LOG:       state_d = IDLE;
`else
      DUTY_LOAD: state_d = IDLE;
`endif
      default:   state_d = IDLE;
    endcase
  end

  // Output and timer next values, decoded from the upcoming state so strobes align with it
  always_comb begin
    adc_start_d  = (state_d == ADC_REQ);
    pid_step_d   = (state_d == PID_STEP);
    duty_load_d  = (state_d == DUTY_LOAD);
    fifo_wr_en_d = 1'b0;
    busy_d       = (state_d != IDLE);
    fault_d      = fault_q;
    timer_d      = timer_q + TMR_W'(1);
`ifdef SEQ_TELEMETRY_EN
    fifo_wr_en_d = (state_d == LOG) && !bus.fifo_full;
`endif
    if ((state_q == IDLE) || (state_d != state_q)) begin
      timer_d = '0;
    end
    if (run_rise) begin
      fault_d = 1'b0;
    end else if (adc_timeout && (consec_cnt >= CNT_WIDTH'(MAX_FAULTS - 1))) begin
      fault_d = 1'b1;
    end
    duty_safe_d = fault_d | ~run_en;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q      <= '0;
      adc_start_q  <= 1'b0;
      pid_step_q   <= 1'b0;
      duty_load_q  <= 1'b0;
      fifo_wr_en_q <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      duty_safe_q  <= 1'b1;
      run_en_q     <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      adc_start_q  <= adc_start_d;
      pid_step_q   <= pid_step_d;
      duty_load_q  <= duty_load_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      duty_safe_q  <= duty_safe_d;
      run_en_q     <= run_en;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_overrun_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (1'b0),
    .inc_i (tick_in && (state_q != IDLE)),
    .cnt_o (overrun_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_timeout_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (1'b0),
    .inc_i (adc_timeout),
    .cnt_o (timeout_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_consec_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (consec_clr),
    .inc_i (adc_timeout),
    .cnt_o (consec_cnt)
  );

`ifndef SEQ_TELEMETRY_EN
  logic unused_fifo_full;
  assign unused_fifo_full = bus.fifo_full;
`endif

  assign bus.adc_start  = adc_start_q;
  assign bus.pid_step   = pid_step_q;
  assign bus.duty_load  = duty_load_q;
  assign bus.duty_safe  = duty_safe_q;
  assign bus.fifo_wr_en = fifo_wr_en_q;
  assign busy           = busy_q;
  assign fault          = fault_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_control_loop_sequencer.sv
// Directed bench for control_loop_sequencer with a shortened ADC timeout of 100 cycles.
module tb_control_loop_sequencer;
  import ctrl_seq_pkg::*;

  localparam int unsigned TO = 100;
  localparam int unsigned CW = 8;
`ifdef SEQ_TELEMETRY_EN
  localparam int TEL = 1;
`else
  localparam int TEL = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tick_in;
  logic          run_en;
  logic          busy;
  logic          fault;
  logic [CW-1:0] overrun_cnt;
  logic [CW-1:0] timeout_cnt;
  logic [2:0]    state_dbg;
  logic [3:0]    strobes;

  int vectors = 0;
  int miscompares = 0;
  int n_adc = 0, n_pid = 0, n_duty = 0, n_fifo = 0, onehot_errs = 0;

  control_loop_sequencer_if bus ();

  control_loop_sequencer #(.ADC_TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick_in     (tick_in),
    .run_en      (run_en),
    .bus         (bus),
    .busy        (busy),
    .fault       (fault),
    .overrun_cnt (overrun_cnt),
    .timeout_cnt (timeout_cnt),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  assign strobes = {bus.adc_start, bus.pid_step, bus.duty_load, bus.fifo_wr_en};

  // Strobe pulse counters and at-most-one-strobe watch, sampled before each edge updates
  always @(posedge clk) begin
    if (reset_n) begin
      if (bus.adc_start)  n_adc++;
      if (bus.pid_step)   n_pid++;
      if (bus.duty_load)  n_duty++;
      if (bus.fifo_wr_en) n_fifo++;
      if ($countones(strobes) > 1) onehot_errs++;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run_en = 1'b1; tick_in = 1'b0;
    bus.adc_done = 1'b0; bus.fifo_full = 1'b0;
    step(); step();
    vectors++; if (bus.adc_start !== 1'b0)  begin miscompares++; $display("FAIL reset adc_start: got %b want 0", bus.adc_start); end
    vectors++; if (bus.pid_step !== 1'b0)   begin miscompares++; $display("FAIL reset pid_step: got %b want 0", bus.pid_step); end
    vectors++; if (bus.duty_load !== 1'b0)  begin miscompares++; $display("FAIL reset duty_load: got %b want 0", bus.duty_load); end
    vectors++; if (bus.fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset fifo_wr_en: got %b want 0", bus.fifo_wr_en); end
    vectors++; if (busy !== 1'b0)           begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
    vectors++; if (fault !== 1'b0)          begin miscompares++; $display("FAIL reset fault: got %b want 0", fault); end
    vectors++; if (overrun_cnt !== '0)      begin miscompares++; $display("FAIL reset overrun_cnt: got %0d want 0", overrun_cnt); end
    vectors++; if (timeout_cnt !== '0)      begin miscompares++; $display("FAIL reset timeout_cnt: got %0d want 0", timeout_cnt); end
    vectors++; if (bus.duty_safe !== 1'b1)  begin miscompares++; $display("FAIL reset duty_safe: got %b want 1", bus.duty_safe); end
    vectors++; if (state_dbg !== 3'd0)      begin miscompares++; $display("FAIL reset state_dbg: got %0d want 0", state_dbg); end
    reset_n = 1'b1;
    step(); step();
    vectors++; if (bus.duty_safe !== 1'b0)  begin miscompares++; $display("FAIL run duty_safe: got %b want 0", bus.duty_safe); end
  endtask

  task automatic test_nominal();
    int delays[2] = '{50, 5};
    logic e_pid, e_duty, e_fifo, e_busy;
    foreach (delays[i]) begin
      int d = delays[i];
      pulse_tick();
      vectors++; if (bus.adc_start !== 1'b1) begin miscompares++; $display("FAIL nominal adc_start d=%0d: got %b want 1", d, bus.adc_start); end
      vectors++; if (state_dbg !== 3'(ADC_REQ)) begin miscompares++; $display("FAIL nominal state d=%0d: got %0d want 1", d, state_dbg); end
      for (int c = 1; c <= d + 12; c++) begin
        step();
        bus.adc_done = (c == d);
        e_pid  = (c == d + 3);
        e_duty = (c == d + 7);
        e_fifo = (TEL == 1) && (c == d + 8);
        e_busy = (c <= d + 7 + TEL);
        vectors++; if (bus.adc_start !== 1'b0)  begin miscompares++; $display("FAIL nominal extra adc_start d=%0d c=%0d", d, c); end
        vectors++; if (bus.pid_step !== e_pid)  begin miscompares++; $display("FAIL nominal pid_step d=%0d c=%0d: got %b want %b", d, c, bus.pid_step, e_pid); end
        vectors++; if (bus.duty_load !== e_duty) begin miscompares++; $display("FAIL nominal duty_load d=%0d c=%0d: got %b want %b", d, c, bus.duty_load, e_duty); end
        vectors++; if (bus.fifo_wr_en !== e_fifo) begin miscompares++; $display("FAIL nominal fifo_wr_en d=%0d c=%0d: got %b want %b", d, c, bus.fifo_wr_en, e_fifo); end
        vectors++; if (busy !== e_busy)         begin miscompares++; $display("FAIL nominal busy d=%0d c=%0d: got %b want %b", d, c, busy, e_busy); end
        if (c == d + 1) begin
          vectors++; if (state_dbg !== 3'(LUT_WAIT)) begin miscompares++; $display("FAIL nominal lut state d=%0d: got %0d want 3", d, state_dbg); end
        end
      end
    end
  endtask

  task automatic test_overrun();
    int b_adc = n_adc, b_pid = n_pid, b_duty = n_duty;
    pulse_tick();
    for (int c = 1; c <= 62; c++) begin
      step();
      tick_in = (c == 20);
      bus.adc_done = (c == 50);
    end
    vectors++; if (overrun_cnt !== CW'(1)) begin miscompares++; $display("FAIL overrun cnt: got %0d want 1", overrun_cnt); end
    vectors++; if (n_adc - b_adc !== 1)   begin miscompares++; $display("FAIL overrun adc_starts: got %0d want 1", n_adc - b_adc); end
    vectors++; if (n_pid - b_pid !== 1)   begin miscompares++; $display("FAIL overrun pid_steps: got %0d want 1", n_pid - b_pid); end
    vectors++; if (n_duty - b_duty !== 1) begin miscompares++; $display("FAIL overrun duty_loads: got %0d want 1", n_duty - b_duty); end
    vectors++; if (busy !== 1'b0)         begin miscompares++; $display("FAIL overrun busy end: got %b want 0", busy); end
  endtask

  task automatic test_timeout_fault();
    int b_adc;
    for (int k = 1; k <= 3; k++) begin
      pulse_tick();
      vectors++; if (bus.adc_start !== 1'b1) begin miscompares++; $display("FAIL timeout adc_start k=%0d: got %b want 1", k, bus.adc_start); end
      for (int c = 1; c <= 101; c++) begin
        step();
        if (c == 100) begin
          vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL timeout early exit k=%0d: busy %b want 1", k, busy); end
          vectors++; if (timeout_cnt !== CW'(k - 1)) begin miscompares++; $display("FAIL timeout early cnt k=%0d: got %0d want %0d", k, timeout_cnt, k - 1); end
        end
        if (c == 101) begin
          vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL timeout exit k=%0d: busy %b want 0", k, busy); end
          vectors++; if (timeout_cnt !== CW'(k)) begin miscompares++; $display("FAIL timeout cnt k=%0d: got %0d want %0d", k, timeout_cnt, k); end
          vectors++; if (fault !== logic'(k == 3)) begin miscompares++; $display("FAIL timeout fault k=%0d: got %b want %b", k, fault, k == 3); end
          vectors++; if (bus.duty_safe !== logic'(k == 3)) begin miscompares++; $display("FAIL timeout duty_safe k=%0d: got %b want %b", k, bus.duty_safe, k == 3); end
        end
      end
      step();
    end
    b_adc = n_adc;
    pulse_tick();
    vectors++; if (bus.adc_start !== 1'b0) begin miscompares++; $display("FAIL fault tick adc_start: got %b want 0", bus.adc_start); end
    vectors++; if (state_dbg !== 3'd0)     begin miscompares++; $display("FAIL fault tick state: got %0d want 0", state_dbg); end
    repeat (3) step();
    vectors++; if (n_adc !== b_adc)        begin miscompares++; $display("FAIL fault tick adc_starts: got %0d want %0d", n_adc, b_adc); end
    vectors++; if (overrun_cnt !== CW'(1)) begin miscompares++; $display("FAIL fault tick overrun: got %0d want 1", overrun_cnt); end
    run_en = 1'b0;
    step(); step();
    vectors++; if (fault !== 1'b1)         begin miscompares++; $display("FAIL fault while run_en low: got %b want 1", fault); end
    vectors++; if (bus.duty_safe !== 1'b1) begin miscompares++; $display("FAIL duty_safe run_en low: got %b want 1", bus.duty_safe); end
    run_en = 1'b1;
    step();
    vectors++; if (fault !== 1'b0)         begin miscompares++; $display("FAIL fault clear: got %b want 0", fault); end
    vectors++; if (bus.duty_safe !== 1'b0) begin miscompares++; $display("FAIL duty_safe after clear: got %b want 0", bus.duty_safe); end
    pulse_tick();
    repeat (102) step();
    vectors++; if (timeout_cnt !== CW'(4)) begin miscompares++; $display("FAIL timeout after clear cnt: got %0d want 4", timeout_cnt); end
    vectors++; if (fault !== 1'b0)         begin miscompares++; $display("FAIL single timeout after clear: fault %b want 0", fault); end
  endtask

  task automatic test_timeout_boundary();
    pulse_tick();
    for (int c = 1; c <= 112; c++) begin
      step();
      bus.adc_done = (c == 100);
      if (c == 101) begin
        vectors++; if (state_dbg !== 3'(LUT_WAIT)) begin miscompares++; $display("FAIL boundary state: got %0d want 3", state_dbg); end
        vectors++; if (timeout_cnt !== CW'(4))     begin miscompares++; $display("FAIL boundary timeout_cnt: got %0d want 4", timeout_cnt); end
      end
      if (c == 103) begin
        vectors++; if (bus.pid_step !== 1'b1) begin miscompares++; $display("FAIL boundary pid_step: got %b want 1", bus.pid_step); end
      end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL boundary busy end: got %b want 0", busy); end
  endtask

  task automatic test_abort();
    int b_pid = n_pid, b_duty = n_duty;
    pulse_tick();
    for (int c = 1; c <= 45; c++) begin
      step();
      if (c == 20) run_en = 1'b0;
      bus.adc_done = (c == 30);
      if (c == 25) begin
        vectors++; if (state_dbg !== 3'(ADC_WAIT)) begin miscompares++; $display("FAIL abort still waiting: state %0d want 2", state_dbg); end
        vectors++; if (bus.duty_safe !== 1'b1)     begin miscompares++; $display("FAIL abort duty_safe: got %b want 1", bus.duty_safe); end
      end
      if (c == 31) begin
        vectors++; if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL abort return idle: state %0d want 0", state_dbg); end
      end
    end
    vectors++; if (n_pid !== b_pid)   begin miscompares++; $display("FAIL abort pid_steps: got %0d want %0d", n_pid, b_pid); end
    vectors++; if (n_duty !== b_duty) begin miscompares++; $display("FAIL abort duty_loads: got %0d want %0d", n_duty, b_duty); end
    run_en = 1'b1;
    step();
    pulse_tick();
    for (int c = 1; c <= 20; c++) begin
      step();
      bus.adc_done = (c == 5);
      if (c == 9) run_en = 1'b0;
      if (c == 10) begin
        vectors++; if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL pid_wait abort: state %0d want 0", state_dbg); end
      end
    end
    vectors++; if (n_pid !== b_pid + 1) begin miscompares++; $display("FAIL pid_wait abort pid_steps: got %0d want %0d", n_pid, b_pid + 1); end
    vectors++; if (n_duty !== b_duty)   begin miscompares++; $display("FAIL pid_wait abort duty_loads: got %0d want %0d", n_duty, b_duty); end
    run_en = 1'b1;
    step();
  endtask

  task automatic test_fifo_full();
    int b_duty = n_duty, b_fifo = n_fifo;
    bus.fifo_full = 1'b1;
    pulse_tick();
    for (int c = 1; c <= 20; c++) begin
      step();
      bus.adc_done = (c == 5);
      if (c == 13) begin
        vectors++; if (state_dbg !== 3'(TEL == 1 ? 7 : 0)) begin miscompares++; $display("FAIL fifo_full log state: got %0d want %0d", state_dbg, TEL == 1 ? 7 : 0); end
      end
    end
    vectors++; if (n_duty !== b_duty + 1) begin miscompares++; $display("FAIL fifo_full duty_loads: got %0d want %0d", n_duty, b_duty + 1); end
    vectors++; if (n_fifo !== b_fifo)     begin miscompares++; $display("FAIL fifo_full pushes: got %0d want %0d", n_fifo, b_fifo); end
    vectors++; if (busy !== 1'b0)         begin miscompares++; $display("FAIL fifo_full busy end: got %b want 0", busy); end
    bus.fifo_full = 1'b0;
  endtask

  task automatic test_reset_mid();
    pulse_tick();
    for (int c = 1; c <= 9; c++) begin
      step();
      bus.adc_done = (c == 5);
      tick_in = (c == 2);
    end
    vectors++; if (state_dbg !== 3'(PID_WAIT)) begin miscompares++; $display("FAIL mid state pre-reset: got %0d want 5", state_dbg); end
    vectors++; if (overrun_cnt !== CW'(2))     begin miscompares++; $display("FAIL mid overrun pre-reset: got %0d want 2", overrun_cnt); end
    vectors++; if (timeout_cnt !== CW'(4))     begin miscompares++; $display("FAIL mid timeout pre-reset: got %0d want 4", timeout_cnt); end
    reset_n = 1'b0;
    #1;
    vectors++; if (strobes !== 4'b0)       begin miscompares++; $display("FAIL mid reset strobes: got %b want 0000", strobes); end
    vectors++; if (overrun_cnt !== '0)     begin miscompares++; $display("FAIL mid reset overrun: got %0d want 0", overrun_cnt); end
    vectors++; if (timeout_cnt !== '0)     begin miscompares++; $display("FAIL mid reset timeout: got %0d want 0", timeout_cnt); end
    vectors++; if (bus.duty_safe !== 1'b1) begin miscompares++; $display("FAIL mid reset duty_safe: got %b want 1", bus.duty_safe); end
    vectors++; if (state_dbg !== 3'd0)     begin miscompares++; $display("FAIL mid reset state: got %0d want 0", state_dbg); end
    vectors++; if (busy !== 1'b0)          begin miscompares++; $display("FAIL mid reset busy: got %b want 0", busy); end
    step();
    reset_n = 1'b1;
    step(); step();
  endtask

  task automatic test_saturation();
    bus.adc_done = 1'b1;
    tick_in = 1'b1;
    repeat (800) step();
    tick_in = 1'b0;
    bus.adc_done = 1'b0;
    repeat (20) step();
    vectors++; if (overrun_cnt !== 8'hFF) begin miscompares++; $display("FAIL overrun saturation: got %0d want 255", overrun_cnt); end
    vectors++; if (timeout_cnt !== '0)    begin miscompares++; $display("FAIL saturation timeout_cnt: got %0d want 0", timeout_cnt); end
    vectors++; if (busy !== 1'b0)         begin miscompares++; $display("FAIL saturation busy end: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overrun();
    test_timeout_fault();
    test_timeout_boundary();
    test_abort();
    test_fifo_full();
    test_reset_mid();
    test_saturation();
    vectors++; if (onehot_errs !== 0) begin miscompares++; $display("FAIL strobe exclusivity: %0d cycles with multiple strobes, want 0", onehot_errs); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
